// File: rtl/cmd_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// cmd_issue_queue_pkg
// Shared definitions for the controller / issue-queue pair:
//   - controller state encodings (INPUT -> RF_RW -> [COMPUTE -> RF_W] -> INPUT)
//   - issue-slot state encoding
//   - instruction field widths and the packed instruction word width
//   - default command driven while no instruction is issued
// -----------------------------------------------------------------------------
package cmd_issue_queue_pkg;

    typedef enum logic [1:0] {
        STATE_INPUT   = 2'b00,
        STATE_RF_RW   = 2'b01,
        STATE_COMPUTE = 2'b10,
        STATE_RF_W    = 2'b11
    } ctrl_state_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_BUSY  = 1'b1
    } slot_state_e;

    localparam int CMD_W             = 3;
    localparam int DEFAULT_RF_ADDR_W = 3;
    localparam int DEFAULT_DATA_W    = 8;

    localparam logic [CMD_W-1:0] DEFAULT_IDLE_CMD = 3'b000;

    // Packed word layout, MSB to LSB: {cmd, rd, rs1, rs2, imm}.
    function automatic int instr_word_w(input int rf_addr_w, input int data_w);
        return CMD_W + 3 * rf_addr_w + data_w;
    endfunction

endpackage

// File: rtl/cmd_issue_queue_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Parameterised circular buffer. Push is ignored when full and pop is ignored
// when empty, so the occupancy can never leave [0, DEPTH]. The head entry is
// presented combinationally on o_rd_data.
//
// Ports:
//   clk, rst_n   clock (posedge) and asynchronous active-low reset
//   i_push       write i_wr_data at the tail (ignored when full)
//   i_wr_data    word to enqueue
//   i_pop        drop the head entry (ignored when empty)
//   o_rd_data    current head entry (undefined content when empty)
//   o_full       occupancy == DEPTH
//   o_empty      occupancy == 0
//   o_count      occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // a blocking = here would let later statements see the new value.
    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only read once the pointers say
    // they were written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/cmd_issue_queue.sv
// -----------------------------------------------------------------------------
// cmd_issue_queue
// Buffers instruction words from the operator/input logic and presents exactly
// one of them to the multi-cycle controller and datapath. A new instruction is
// taken from the FIFO on every edge where the controller sits in INPUT; the
// issue registers hold through RF_RW/COMPUTE/RF_W. If the FIFO is empty at that
// edge a bubble (IDLE_CMD, issue_valid = 0) is issued instead. The controller's
// done pulse retires the issued instruction on that same INPUT edge.
//
// Ports:
//   clk, rst_n                  clock (posedge), asynchronous active-low reset
//   in_valid / in_ready         producer handshake; in_ready = (count != DEPTH)
//   in_cmd, in_rd, in_rs1,
//   in_rs2, in_imm              instruction word fields
//   ctrl_state                  controller current state
//   ctrl_done                   controller done pulse (in INPUT after a txn)
//   issue_valid                 issued slot holds a real instruction
//   issue_cmd, issue_rd,
//   issue_rs1, issue_rs2,
//   issue_imm                   issued instruction fields
//   count                       FIFO occupancy
//   retire_count                retired instructions, wraps 255 -> 0
// -----------------------------------------------------------------------------
module cmd_issue_queue
    import cmd_issue_queue_pkg::*;
#(
    parameter  int               DEPTH     = 4,
    parameter  int               RF_ADDR_W = DEFAULT_RF_ADDR_W,
    parameter  int               DATA_W    = DEFAULT_DATA_W,
    parameter  logic [CMD_W-1:0] IDLE_CMD  = DEFAULT_IDLE_CMD,
    localparam int               CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CMD_W-1:0]     in_cmd,
    input  logic [RF_ADDR_W-1:0] in_rd,
    input  logic [RF_ADDR_W-1:0] in_rs1,
    input  logic [RF_ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0]    in_imm,

    input  logic [1:0]           ctrl_state,
    input  logic                 ctrl_done,

    output logic                 issue_valid,
    output logic [CMD_W-1:0]     issue_cmd,
    output logic [RF_ADDR_W-1:0] issue_rd,
    output logic [RF_ADDR_W-1:0] issue_rs1,
    output logic [RF_ADDR_W-1:0] issue_rs2,
    output logic [DATA_W-1:0]    issue_imm,
    output logic [CNT_W-1:0]     count,
    output logic [7:0]           retire_count
);

    localparam int WORD_W  = instr_word_w(RF_ADDR_W, DATA_W);
    localparam int IMM_LSB = 0;
    localparam int RS2_LSB = DATA_W;
    localparam int RS1_LSB = DATA_W + RF_ADDR_W;
    localparam int RD_LSB  = DATA_W + 2 * RF_ADDR_W;
    localparam int CMD_LSB = DATA_W + 3 * RF_ADDR_W;

    logic [WORD_W-1:0] w_wr_word;
    logic [WORD_W-1:0] w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_issue_edge;
    logic              w_retire;

    slot_state_e       r_slot_state;
    slot_state_e       w_slot_next;

    logic [CMD_W-1:0]     r_issue_cmd;
    logic [RF_ADDR_W-1:0] r_issue_rd;
    logic [RF_ADDR_W-1:0] r_issue_rs1;
    logic [RF_ADDR_W-1:0] r_issue_rs2;
    logic [DATA_W-1:0]    r_issue_imm;
    logic [7:0]           r_retire_count;

    assign w_wr_word    = {in_cmd, in_rd, in_rs1, in_rs2, in_imm};
    assign in_ready     = !w_fifo_full;
    assign w_push       = in_valid && in_ready;
    assign w_issue_edge = (ctrl_state == STATE_INPUT);
    // The pop sees the pre-edge occupancy, so a word pushed on this same edge
    // into an empty FIFO is not bypassed; it issues on the next INPUT edge.
    assign w_pop        = w_issue_edge && !w_fifo_empty;
    assign w_retire     = ctrl_done && issue_valid;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wr_data (w_wr_word),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (count)
    );

    // Issue-slot FSM: SLOT_BUSY exactly when a real instruction is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_slot_state <= SLOT_EMPTY;
        else        r_slot_state <= w_slot_next;
    end

    // NOTE: every output of this block is assigned a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_slot_next = r_slot_state;
        issue_valid = (r_slot_state == SLOT_BUSY);
        if (w_issue_edge) begin
            w_slot_next = w_fifo_empty ? SLOT_EMPTY : SLOT_BUSY;
        end
    end

    // Issue registers only change on INPUT edges, keeping the instruction
    // stable for the whole RF_RW/COMPUTE/RF_W sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cmd <= IDLE_CMD;
            r_issue_rd  <= '0;
            r_issue_rs1 <= '0;
            r_issue_rs2 <= '0;
            r_issue_imm <= '0;
        end else if (w_issue_edge) begin
            if (!w_fifo_empty) begin
                r_issue_cmd <= w_head[CMD_LSB +: CMD_W];
                r_issue_rd  <= w_head[RD_LSB  +: RF_ADDR_W];
                r_issue_rs1 <= w_head[RS1_LSB +: RF_ADDR_W];
                r_issue_rs2 <= w_head[RS2_LSB +: RF_ADDR_W];
                r_issue_imm <= w_head[IMM_LSB +: DATA_W];
            end else begin
                r_issue_cmd <= IDLE_CMD;
                r_issue_rd  <= '0;
                r_issue_rs1 <= '0;
                r_issue_rs2 <= '0;
                r_issue_imm <= '0;
            end
        end
    end

    // Bubble transactions also end with ctrl_done but are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_retire_count <= '0;
        else if (w_retire) r_retire_count <= r_retire_count + 8'd1;
    end

    assign issue_cmd    = r_issue_cmd;
    assign issue_rd     = r_issue_rd;
    assign issue_rs1    = r_issue_rs1;
    assign issue_rs2    = r_issue_rs2;
    assign issue_imm    = r_issue_imm;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_cmd_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_cmd_issue_queue
// Directed scenarios plus a randomized run of a model controller, all checked
// against a queue-based reference of the issue queue's behaviour.
// -----------------------------------------------------------------------------
module tb_cmd_issue_queue;
    import cmd_issue_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0] cmd;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [7:0] imm;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_cmd;
    logic [2:0] in_rd;
    logic [2:0] in_rs1;
    logic [2:0] in_rs2;
    logic [7:0] in_imm;
    logic [1:0] ctrl_state;
    logic       ctrl_done;
    logic       issue_valid;
    logic [2:0] issue_cmd;
    logic [2:0] issue_rd;
    logic [2:0] issue_rs1;
    logic [2:0] issue_rs2;
    logic [7:0] issue_imm;
    logic [2:0] count;
    logic [7:0] retire_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    word_t      m_q[$];
    word_t      m_slot;
    logic       m_valid;
    logic [7:0] m_retire;

    cmd_issue_queue #(
        .DEPTH     (DEPTH),
        .RF_ADDR_W (3),
        .DATA_W    (8),
        .IDLE_CMD  (3'b000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cmd       (in_cmd),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .ctrl_state   (ctrl_state),
        .ctrl_done    (ctrl_done),
        .issue_valid  (issue_valid),
        .issue_cmd    (issue_cmd),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_imm    (issue_imm),
        .count        (count),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_slot   = '0;
        m_valid  = 1'b0;
        m_retire = 8'd0;
    endtask

    // One clock edge of the reference: retire, then issue from the pre-edge
    // queue contents, then enqueue the offered word if there was room.
    task automatic model_edge();
        bit    accept;
        word_t w;
        accept = in_valid && (m_q.size() < DEPTH);
        w      = '{cmd: in_cmd, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
        if (ctrl_done && m_valid) m_retire = m_retire + 8'd1;
        if (ctrl_state == STATE_INPUT) begin
            if (m_q.size() > 0) begin
                m_slot  = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_slot  = '0;
                m_valid = 1'b0;
            end
        end
        if (accept) m_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive_in(input logic v, input word_t w);
        in_valid = v;
        in_cmd   = w.cmd;
        in_rd    = w.rd;
        in_rs1   = w.rs1;
        in_rs2   = w.rs2;
        in_imm   = w.imm;
    endtask

    task automatic drive_ctrl(input ctrl_state_e st, input logic done);
        ctrl_state = st;
        ctrl_done  = done;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_in(1'b0, '0);
        drive_ctrl(STATE_RF_RW, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_issue_valid got=%0b exp=0", issue_valid); end
        n_vec++; if (issue_cmd !== 3'b000) begin n_err++; $display("FAIL reset_issue_cmd got=%03b exp=000", issue_cmd); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        n_vec++; if (retire_count !== 8'd0) begin n_err++; $display("FAIL reset_retire_count got=%0d exp=0", retire_count); end
    endtask

    task automatic test_single_op();
        word_t w = '{cmd: 3'b101, rd: 3'd2, rs1: 3'd1, rs2: 3'd3, imm: 8'h5A};
        ctrl_state_e seq[3] = '{STATE_RF_RW, STATE_COMPUTE, STATE_RF_W};
        apply_reset();
        drive_in(1'b1, w); drive_ctrl(STATE_RF_W, 1'b0); tick();
        n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count_after_push got=%0d exp=1", count); end
        drive_in(1'b0, '0); drive_ctrl(STATE_INPUT, 1'b0); tick();
        n_vec++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL single_issue_valid got=%0b exp=1", issue_valid); end
        n_vec++; if ({issue_cmd, issue_rd, issue_rs1, issue_rs2, issue_imm} !== w)
            begin n_err++; $display("FAIL single_issue_word got=%h exp=%h", {issue_cmd, issue_rd, issue_rs1, issue_rs2, issue_imm}, w); end
        for (int i = 0; i < 3; i++) begin
            drive_ctrl(seq[i], 1'b0); tick();
            n_vec++; if ({issue_valid, issue_cmd, issue_rd, issue_rs1, issue_rs2, issue_imm} !== {1'b1, w})
                begin n_err++; $display("FAIL single_hold_%0d got=%h exp=%h", i, {issue_valid, issue_cmd, issue_rd, issue_rs1, issue_rs2, issue_imm}, {1'b1, w}); end
        end
        drive_ctrl(STATE_INPUT, 1'b1); tick();
        n_vec++; if (retire_count !== 8'd1) begin n_err++; $display("FAIL single_retire got=%0d exp=1", retire_count); end
        n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL single_bubble_after got=%0b exp=0", issue_valid); end
    endtask

    task automatic test_fill_backpressure();
        word_t first;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            word_t w = word_t'($urandom);
            if (i == 0) first = w;
            drive_in(1'b1, w); drive_ctrl(STATE_RF_RW, 1'b0); tick();
        end
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got=%0d exp=4", count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
        drive_in(1'b1, word_t'($urandom)); tick();
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_fifth_rejected got=%0d exp=4", count); end
        drive_in(1'b0, '0); drive_ctrl(STATE_INPUT, 1'b0); tick();
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL fill_after_pop_count got=%0d exp=3", count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_after_pop_ready got=%0b exp=1", in_ready); end
        n_vec++; if (issue_cmd !== first.cmd || issue_imm !== first.imm)
            begin n_err++; $display("FAIL fill_first_issued got=%03b/%h exp=%03b/%h", issue_cmd, issue_imm, first.cmd, first.imm); end
    endtask

    task automatic test_order();
        logic [2:0] cmds[4] = '{3'b001, 3'b110, 3'b011, 3'b100};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            word_t w = word_t'($urandom);
            w.cmd = cmds[i];
            drive_in(1'b1, w); drive_ctrl(STATE_RF_W, 1'b0); tick();
        end
        drive_in(1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            drive_ctrl(STATE_INPUT, k > 0); tick();
            n_vec++; if ({issue_valid, issue_cmd} !== {1'b1, cmds[k]})
                begin n_err++; $display("FAIL order_%0d got=%0b/%03b exp=1/%03b", k, issue_valid, issue_cmd, cmds[k]); end
            drive_ctrl(STATE_RF_RW, 1'b0); tick();
            drive_ctrl(STATE_COMPUTE, 1'b0); tick();
            drive_ctrl(STATE_RF_W, 1'b0); tick();
        end
        drive_ctrl(STATE_INPUT, 1'b1); tick();
        n_vec++; if (retire_count !== 8'd4) begin n_err++; $display("FAIL order_retire got=%0d exp=4", retire_count); end
    endtask

    task automatic test_empty_push_on_issue();
        word_t w = '{cmd: 3'b010, rd: 3'd5, rs1: 3'd6, rs2: 3'd7, imm: 8'hC3};
        apply_reset();
        drive_ctrl(STATE_RF_W, 1'b0); tick();
        drive_in(1'b1, w); drive_ctrl(STATE_INPUT, 1'b0); tick();
        n_vec++; if ({issue_valid, issue_cmd} !== 4'b0_000)
            begin n_err++; $display("FAIL bypass_bubble got=%0b/%03b exp=0/000", issue_valid, issue_cmd); end
        n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL bypass_count got=%0d exp=1", count); end
        drive_in(1'b0, '0);
        drive_ctrl(STATE_RF_RW, 1'b0); tick();
        drive_ctrl(STATE_INPUT, 1'b1); tick();
        n_vec++; if (retire_count !== 8'd0) begin n_err++; $display("FAIL bypass_bubble_retired got=%0d exp=0", retire_count); end
        n_vec++; if ({issue_valid, issue_cmd, issue_imm} !== {1'b1, 3'b010, 8'hC3})
            begin n_err++; $display("FAIL bypass_next_issue got=%0b/%03b/%h exp=1/010/c3", issue_valid, issue_cmd, issue_imm); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, word_t'($urandom)); drive_ctrl(STATE_RF_RW, 1'b0); tick();
        end
        drive_in(1'b0, '0); drive_ctrl(STATE_INPUT, 1'b0); tick();
        drive_ctrl(STATE_RF_RW, 1'b0); tick();
        drive_ctrl(STATE_INPUT, 1'b1); tick();
        drive_in(1'b1, word_t'($urandom)); drive_ctrl(STATE_RF_RW, 1'b0); tick();
        drive_in(1'b0, '0);
        n_vec++; if ({count, issue_valid, retire_count} !== {3'd2, 1'b1, 8'd1})
            begin n_err++; $display("FAIL async_pre got=%0d/%0b/%0d exp=2/1/1", count, issue_valid, retire_count); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({count, issue_valid, retire_count} !== {3'd0, 1'b0, 8'd0})
            begin n_err++; $display("FAIL async_clear got=%0d/%0b/%0d exp=0/0/0", count, issue_valid, retire_count); end
        n_vec++; if ({in_ready, issue_cmd} !== 4'b1_000)
            begin n_err++; $display("FAIL async_ready_cmd got=%0b/%03b exp=1/000", in_ready, issue_cmd); end
        apply_reset();
    endtask

    task automatic test_random();
        ctrl_state_e st   = STATE_INPUT;
        logic        done = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int pct = (cyc < 300) ? 65 : 20;
            drive_in($urandom_range(0, 99) < pct, word_t'($urandom));
            drive_ctrl(st, done);
            tick();
            n_vec++; if (count !== 3'(m_q.size()))
                begin n_err++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count, m_q.size()); end
            n_vec++; if (in_ready !== (m_q.size() != DEPTH))
                begin n_err++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, m_q.size() != DEPTH); end
            n_vec++; if (issue_valid !== m_valid)
                begin n_err++; $display("FAIL rand_issue_valid cyc=%0d got=%0b exp=%0b", cyc, issue_valid, m_valid); end
            n_vec++; if (issue_cmd !== m_slot.cmd)
                begin n_err++; $display("FAIL rand_issue_cmd cyc=%0d got=%03b exp=%03b", cyc, issue_cmd, m_slot.cmd); end
            if (m_valid) begin
                n_vec++; if ({issue_rd, issue_rs1, issue_rs2, issue_imm} !== {m_slot.rd, m_slot.rs1, m_slot.rs2, m_slot.imm})
                    begin n_err++; $display("FAIL rand_issue_fields cyc=%0d got=%h exp=%h", cyc, {issue_rd, issue_rs1, issue_rs2, issue_imm}, {m_slot.rd, m_slot.rs1, m_slot.rs2, m_slot.imm}); end
            end
            n_vec++; if (retire_count !== m_retire)
                begin n_err++; $display("FAIL rand_retire cyc=%0d got=%0d exp=%0d", cyc, retire_count, m_retire); end
            // Model controller: INPUT may idle, otherwise run a 2- or 4-state
            // transaction that ends with done in INPUT.
            case (st)
                STATE_INPUT: begin
                    done = 1'b0;
                    st   = ($urandom_range(0, 3) == 0) ? STATE_INPUT : STATE_RF_RW;
                end
                STATE_RF_RW: begin
                    if ($urandom_range(0, 1) == 1) st = STATE_COMPUTE;
                    else begin st = STATE_INPUT; done = 1'b1; end
                end
                STATE_COMPUTE: st = STATE_RF_W;
                default: begin st = STATE_INPUT; done = 1'b1; end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fill_backpressure();
        test_order();
        test_empty_push_on_issue();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
